// File: rtl/rvseed_hazard_ctrl_if.sv
// Signal bundle between the rvseed IFU/IDU/EXU pipeline (master) and the
// hazard/flush sequencing controller (slave).
interface rvseed_hazard_ctrl_if #(
  parameter int RIDX_W = 5,
  parameter int CNT_W  = 32
);
  logic              enable;
  logic              ifu2idu_en;
  logic [RIDX_W-1:0] idu_rs1;
  logic              idu_rs1_used;
  logic [RIDX_W-1:0] idu_rs2;
  logic              idu_rs2_used;
  logic [RIDX_W-1:0] idu_rd;
  logic              idu_reg_wen;
  logic              idu_mem_ren;
  logic              exu_redirect;
  logic              ctrl2ifu_stall;
  logic              ctrl2idu_stall;
  logic              ctrl2exu_bubble;
  logic              ctrl2ifu_flush;
  logic              ctrl2idu_flush;
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output enable, ifu2idu_en, idu_rs1, idu_rs1_used, idu_rs2, idu_rs2_used,
           idu_rd, idu_reg_wen, idu_mem_ren, exu_redirect,
    input  ctrl2ifu_stall, ctrl2idu_stall, ctrl2exu_bubble, ctrl2ifu_flush,
           ctrl2idu_flush, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  enable, ifu2idu_en, idu_rs1, idu_rs1_used, idu_rs2, idu_rs2_used,
           idu_rd, idu_reg_wen, idu_mem_ren, exu_redirect,
    output ctrl2ifu_stall, ctrl2idu_stall, ctrl2exu_bubble, ctrl2ifu_flush,
           ctrl2idu_flush, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/rvseed_hazard_ctrl.sv
// rvseed pipeline sequencing: RAW-hazard stalls from an in-flight write
// scoreboard, multi-cycle flushes on EXU redirects, saturating perf counters.
//
// state    | meaning
// ST_RUN   | normal issue; stalls follow hazard, redirect starts a flush
// ST_FLUSH | IFU/IDU flushed and EXU bubbled while flush_cnt runs down
// ST_IDLE  | enable low; pipeline frozen, flush_cnt remembers unfinished flush
module rvseed_hazard_ctrl #(
  parameter int NSTAGE    = 3,
  parameter int FWD_EN    = 1,
  parameter int FLUSH_CYC = 2,
  parameter int RIDX_W    = 5,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  rvseed_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t            state;
  logic [2:0]        flush_cnt;
  logic [NSTAGE-1:0] sb_valid;
  logic [NSTAGE-1:0] sb_load;
  logic [RIDX_W-1:0] sb_rd [NSTAGE];
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_perf;

  logic match_rs1, match_rs2;
  logic hazard, in_flush, flush_active, issue;

  // With forwarding only a load still in EX cannot supply its result in time.
  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
    if (FWD_EN != 0) begin
      match_rs1 = sb_valid[0] & sb_load[0] & (sb_rd[0] == bus.idu_rs1);
      match_rs2 = sb_valid[0] & sb_load[0] & (sb_rd[0] == bus.idu_rs2);
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (sb_valid[i] && (sb_rd[i] == bus.idu_rs1)) match_rs1 = 1'b1;
        if (sb_valid[i] && (sb_rd[i] == bus.idu_rs2)) match_rs2 = 1'b1;
      end
    end
  end

  assign hazard = bus.ifu2idu_en &
                  ((bus.idu_rs1_used & (bus.idu_rs1 != '0) & match_rs1) |
                   (bus.idu_rs2_used & (bus.idu_rs2 != '0) & match_rs2));

  // An unfinished flush parked in IDLE resumes in the very cycle enable returns.
  assign in_flush     = (state == ST_FLUSH) | ((state == ST_IDLE) & (flush_cnt != '0));
  assign flush_active = bus.enable & (in_flush | bus.exu_redirect);
  assign issue        = bus.enable & bus.ifu2idu_en & ~hazard & ~flush_active;

  assign bus.ctrl2ifu_stall  = ~bus.enable | (hazard & ~flush_active);
  assign bus.ctrl2idu_stall  = ~bus.enable | (hazard & ~flush_active);
  assign bus.ctrl2exu_bubble = bus.enable & (flush_active | hazard | ~bus.ifu2idu_en);
  assign bus.ctrl2ifu_flush  = flush_active;
  assign bus.ctrl2idu_flush  = flush_active;
  assign bus.perf_stall_cnt  = stall_cnt;
  assign bus.perf_flush_cnt  = flush_perf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_cnt  <= '0;
      sb_valid   <= '0;
      sb_load    <= '0;
      stall_cnt  <= '0;
      flush_perf <= '0;
      for (int i = 0; i < NSTAGE; i++) sb_rd[i] <= '0;
    end else if (!bus.enable) begin
      state <= ST_IDLE;
    end else begin
      for (int i = NSTAGE - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_load[i]  <= sb_load[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
      sb_valid[0] <= issue & bus.idu_reg_wen & (bus.idu_rd != '0);
      sb_load[0]  <= bus.idu_mem_ren;
      sb_rd[0]    <= bus.idu_rd;

      if (bus.exu_redirect) begin
        flush_cnt <= FLUSH_RELOAD;
        state     <= (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
      end else if (in_flush) begin
        flush_cnt <= flush_cnt - 3'd1;
        state     <= (flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
      end else begin
        state <= ST_RUN;
      end

      if (hazard && !flush_active && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_active && (flush_perf != CNT_MAX))
        flush_perf <= flush_perf + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_rvseed_hazard_ctrl.sv
// Bench for rvseed_hazard_ctrl: three configurations share one stimulus stream and
// are each compared every cycle against a register-age reference model.
module tb_rvseed_hazard_ctrl;
  localparam int NS [3] = '{3, 3, 2};
  localparam int FW [3] = '{1, 0, 0};
  localparam int FC [3] = '{2, 2, 1};
  localparam int CW [3] = '{32, 32, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, ifu2idu_en, rs1_used, rs2_used, reg_wen, mem_ren, redirect;
  logic [4:0] rs1, rs2, rd;
  int n_checks = 0;
  int n_err = 0;

  rvseed_hazard_ctrl_if #(.RIDX_W(5), .CNT_W(32)) bus0 ();
  rvseed_hazard_ctrl_if #(.RIDX_W(5), .CNT_W(32)) bus1 ();
  rvseed_hazard_ctrl_if #(.RIDX_W(5), .CNT_W(4))  bus2 ();

  rvseed_hazard_ctrl #(.NSTAGE(3), .FWD_EN(1), .FLUSH_CYC(2), .RIDX_W(5), .CNT_W(32))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  rvseed_hazard_ctrl #(.NSTAGE(3), .FWD_EN(0), .FLUSH_CYC(2), .RIDX_W(5), .CNT_W(32))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  rvseed_hazard_ctrl #(.NSTAGE(2), .FWD_EN(0), .FLUSH_CYC(1), .RIDX_W(5), .CNT_W(4))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.enable = enable;       assign bus1.enable = enable;       assign bus2.enable = enable;
  assign bus0.ifu2idu_en = ifu2idu_en; assign bus1.ifu2idu_en = ifu2idu_en; assign bus2.ifu2idu_en = ifu2idu_en;
  assign bus0.idu_rs1 = rs1;         assign bus1.idu_rs1 = rs1;         assign bus2.idu_rs1 = rs1;
  assign bus0.idu_rs1_used = rs1_used; assign bus1.idu_rs1_used = rs1_used; assign bus2.idu_rs1_used = rs1_used;
  assign bus0.idu_rs2 = rs2;         assign bus1.idu_rs2 = rs2;         assign bus2.idu_rs2 = rs2;
  assign bus0.idu_rs2_used = rs2_used; assign bus1.idu_rs2_used = rs2_used; assign bus2.idu_rs2_used = rs2_used;
  assign bus0.idu_rd = rd;           assign bus1.idu_rd = rd;           assign bus2.idu_rd = rd;
  assign bus0.idu_reg_wen = reg_wen; assign bus1.idu_reg_wen = reg_wen; assign bus2.idu_reg_wen = reg_wen;
  assign bus0.idu_mem_ren = mem_ren; assign bus1.idu_mem_ren = mem_ren; assign bus2.idu_mem_ren = mem_ren;
  assign bus0.exu_redirect = redirect; assign bus1.exu_redirect = redirect; assign bus2.exu_redirect = redirect;

  // Flag vector bits: 4 ifu_stall, 3 idu_stall, 2 exu_bubble, 1 ifu_flush, 0 idu_flush
  logic [4:0]  o_flag [3];
  logic [31:0] o_scnt [3];
  logic [31:0] o_fcnt [3];
  assign o_flag[0] = {bus0.ctrl2ifu_stall, bus0.ctrl2idu_stall, bus0.ctrl2exu_bubble,
                      bus0.ctrl2ifu_flush, bus0.ctrl2idu_flush};
  assign o_flag[1] = {bus1.ctrl2ifu_stall, bus1.ctrl2idu_stall, bus1.ctrl2exu_bubble,
                      bus1.ctrl2ifu_flush, bus1.ctrl2idu_flush};
  assign o_flag[2] = {bus2.ctrl2ifu_stall, bus2.ctrl2idu_stall, bus2.ctrl2exu_bubble,
                      bus2.ctrl2ifu_flush, bus2.ctrl2idu_flush};
  assign o_scnt[0] = bus0.perf_stall_cnt;
  assign o_scnt[1] = bus1.perf_stall_cnt;
  assign o_scnt[2] = {28'd0, bus2.perf_stall_cnt};
  assign o_fcnt[0] = bus0.perf_flush_cnt;
  assign o_fcnt[1] = bus1.perf_flush_cnt;
  assign o_fcnt[2] = {28'd0, bus2.perf_flush_cnt};

  // Reference model: per register, the enabled-cycle number of its latest issued writer.
  int     ecyc [3];
  int     last_wr [3][32];
  bit     last_ld [3][32];
  int     fl_left [3];
  longint scnt [3];
  longint fcnt [3];
  bit     m_hz [3];
  bit     m_fl [3];

  function automatic void m_reset(int k);
    ecyc[k] = 0;
    fl_left[k] = 0;
    scnt[k] = 0;
    fcnt[k] = 0;
    for (int r = 0; r < 32; r++) begin
      last_wr[k][r] = -1000;
      last_ld[k][r] = 1'b0;
    end
  endfunction

  function automatic bit m_match(int k, logic [4:0] r);
    int age;
    if (r == 5'd0) return 1'b0;
    age = ecyc[k] - last_wr[k][r];
    if (FW[k] != 0) return (age == 1) && last_ld[k][r];
    return (age >= 1) && (age <= NS[k]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [4:0] ef;
      bit st, bb;
      m_hz[k] = ifu2idu_en && ((rs1_used && m_match(k, rs1)) || (rs2_used && m_match(k, rs2)));
      m_fl[k] = enable && ((fl_left[k] > 0) || redirect);
      st = !enable || (m_hz[k] && !m_fl[k]);
      bb = enable && (m_fl[k] || m_hz[k] || !ifu2idu_en);
      ef = {st, st, bb, m_fl[k], m_fl[k]};
      chk($sformatf("u%0d.outs", k), 64'(o_flag[k]), 64'(ef));
      chk($sformatf("u%0d.stall_cnt", k), 64'(o_scnt[k]), 64'(scnt[k]));
      chk($sformatf("u%0d.flush_cnt", k), 64'(o_fcnt[k]), 64'(fcnt[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      longint mx;
      mx = (longint'(1) << CW[k]) - 1;
      if (!rst_n) begin
        m_reset(k);
      end else if (enable) begin
        if (ifu2idu_en && !m_hz[k] && !m_fl[k] && reg_wen && (rd != 5'd0)) begin
          last_wr[k][rd] = ecyc[k];
          last_ld[k][rd] = mem_ren;
        end
        ecyc[k]++;
        if (m_hz[k] && !m_fl[k] && scnt[k] < mx) scnt[k]++;
        if (m_fl[k] && fcnt[k] < mx) fcnt[k]++;
        if (redirect) fl_left[k] = FC[k] - 1;
        else if (fl_left[k] > 0) fl_left[k]--;
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic id_in(bit v, logic [4:0] a, bit ua, logic [4:0] b, bit ub,
                       logic [4:0] d, bit w, bit ld);
    ifu2idu_en = v; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
    rd = d; reg_wen = w; mem_ren = ld;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) m_reset(k);
    rst_n = 1'b0; enable = 1'b1; redirect = 1'b0;
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Reset state and enable freeze
    id_in(1, 2, 1, 3, 1, 4, 1, 0);
    sample(); chk("rst.outs", 64'(o_flag[0]), 64'h0); chk("rst.scnt", 64'(o_scnt[0]), 64'h0); tick();
    enable = 1'b0;
    sample(); chk("dis.outs", 64'(o_flag[0]), 64'h18); tick();
    enable = 1'b1;
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // Load-use with forwarding: lw x5 ; add x6,x5,x1
    id_in(1, 0, 0, 0, 0, 5, 1, 1);
    sample(); chk("lu.lw", 64'(o_flag[0][4]), 64'h0); tick();
    id_in(1, 5, 1, 1, 1, 6, 1, 0);
    sample(); chk("lu.stall", 64'(o_flag[0]), 64'h1c); chk("nf.lu_stall", 64'(o_flag[1][4]), 64'h1); tick();
    sample(); chk("lu.issue", 64'(o_flag[0][4]), 64'h0); chk("lu.cnt", 64'(o_scnt[0]), 64'h1); tick();
    step();
    sample(); chk("nf.lu_issue", 64'(o_flag[1][4]), 64'h0); chk("nf.lu_cnt", 64'(o_scnt[1]), 64'h3); tick();
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // No forwarding: addi x7 ; sub x8,x7,x0 stalls three cycles
    id_in(1, 0, 1, 0, 0, 7, 1, 0);
    step();
    id_in(1, 7, 1, 0, 1, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      sample(); chk("nf.stall", 64'(o_flag[1][4]), 64'h1); chk("nf.fwd_nostall", 64'(o_flag[0][4]), 64'h0); tick();
    end
    sample(); chk("nf.issue", 64'(o_flag[1][4]), 64'h0); chk("nf.cnt", 64'(o_scnt[1]), 64'h6); tick();
    // x0 writer then x0 reader
    id_in(1, 0, 0, 0, 0, 0, 1, 1);
    step();
    id_in(1, 0, 1, 0, 1, 9, 1, 0);
    sample(); chk("x0.nf", 64'(o_flag[1][4]), 64'h0); chk("x0.fwd", 64'(o_flag[0][4]), 64'h0); tick();
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // Redirect: two flush cycles
    redirect = 1'b1;
    sample(); chk("rd.c1", 64'(o_flag[0]), 64'h07); tick();
    redirect = 1'b0;
    sample(); chk("rd.c2", 64'(o_flag[0]), 64'h07); tick();
    sample(); chk("rd.end", 64'(o_flag[0][1]), 64'h0); chk("rd.cnt", 64'(o_fcnt[0]), 64'h2); tick();
    // Redirect coincident with load-use
    id_in(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    id_in(1, 5, 1, 1, 1, 6, 1, 0);
    redirect = 1'b1;
    sample(); chk("rdhz.outs", 64'(o_flag[0]), 64'h07); tick();
    redirect = 1'b0;
    id_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Back-to-back redirects: three flush cycles
    redirect = 1'b1;
    step();
    sample(); chk("b2b.c2", 64'(o_flag[0][1]), 64'h1); tick();
    redirect = 1'b0;
    sample(); chk("b2b.c3", 64'(o_flag[0][1]), 64'h1); tick();
    sample(); chk("b2b.end", 64'(o_flag[0][1]), 64'h0); chk("b2b.cnt", 64'(o_fcnt[0]), 64'h7); tick();

    // Enable dropped with one flush cycle left
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("frz.outs", 64'(o_flag[0]), 64'h18); chk("frz.cnt", 64'(o_fcnt[0]), 64'h8); tick();
    end
    enable = 1'b1;
    sample(); chk("frz.resume", 64'(o_flag[0]), 64'h07); tick();
    sample(); chk("frz.run", 64'(o_flag[0][1]), 64'h0); chk("frz.cnt2", 64'(o_fcnt[0]), 64'h9); tick();

    // Reset in the middle of a load-use stall
    id_in(1, 0, 0, 0, 0, 5, 1, 1);
    step();
    id_in(1, 5, 1, 1, 1, 6, 1, 0);
    rst_n = 1'b0;
    sample(); chk("rst.pre", 64'(o_flag[0][4]), 64'h1); tick();
    rst_n = 1'b1;
    sample();
    chk("rst.sb", 64'(o_flag[0][4]), 64'h0);
    chk("rst.scnt0", 64'(o_scnt[0]), 64'h0);
    chk("rst.fcnt0", 64'(o_fcnt[0]), 64'h0);
    tick();

    // Random traffic on a small register set to provoke dense hazards
    for (int i = 0; i < 600; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      redirect = ($urandom_range(0, 99) < 8);
      rst_n    = !((i < 400) && ($urandom_range(0, 99) == 0));
      id_in($urandom_range(0, 4) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 6,
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 6,
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4);
      step();
    end
    rst_n = 1'b1;
    redirect = 1'b0;
    sample(); chk("sat.u2", 64'(o_scnt[2]), 64'hf); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/rvseed_hazard_ctrl.md
Name: rvseed_hazard_ctrl

Overview:
- Pipeline sequencing controller for the rvseed IFU→IDU→EXU path.
- Tracks in-flight register writes in a small scoreboard and stalls IFU/IDU on RAW hazards, inserting bubbles into EXU.
- Sequences multi-cycle flushes on EXU branch/jump redirects.
- Keeps saturating stall/flush performance counters.

Parameters:
- NSTAGE, 3, in-flight stages tracked after ID (EX, MEM, WB), range 1..4.
- FWD_EN, 1, 1 = EXU forwarding exists: stall only on a load in EX; 0 = stall on any in-flight write match.
- FLUSH_CYC, 2, flush duration in cycles, range 1..7.
- RIDX_W, 5, register index width (architectural index, not byte-shifted).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  rvseed enable; 0 freezes the pipeline
- ifu2idu_en  in  1  valid instruction in ID
- idu_rs1  in  RIDX_W  ID source 1 index
- idu_rs1_used  in  1  ID reads rs1
- idu_rs2  in  RIDX_W  ID source 2 index
- idu_rs2_used  in  1  ID reads rs2
- idu_rd  in  RIDX_W  ID destination index
- idu_reg_wen  in  1  ID writes rd
- idu_mem_ren  in  1  ID instruction is a load
- exu_redirect  in  1  EXU branch taken / jal / jalr, one-cycle pulse
- ctrl2ifu_stall  out  1  IFU holds PC
- ctrl2idu_stall  out  1  IDU holds instruction
- ctrl2exu_bubble  out  1  EXU receives NOP this cycle
- ctrl2ifu_flush  out  1  IFU discards fetched instruction
- ctrl2idu_flush  out  1  IDU discards instruction
- perf_stall_cnt  out  CNT_W  hazard stall cycles, saturating
- perf_flush_cnt  out  CNT_W  flush cycles, saturating

Behaviour:
- Reset: rst_n low at a clk edge puts state in RUN, clears all scoreboard entries, zeroes both counters and flush_cnt. Reset overrides everything, including a flush in progress.
- After reset, all outputs are 0 except ctrl2*_stall, which equal (enable==0).
- Scoreboard: NSTAGE entries {valid, rd, load}. Entry 0 is EX.
  - Each enabled cycle, entries shift 0→1→…→NSTAGE-1; the last entry drops.
  - Entry 0 loads from ID when issue = ifu2idu_en & !hazard & !flush_active. It loads valid = idu_reg_wen & (idu_rd != 0).
  - Otherwise entry 0 is loaded invalid.
- hazard (combinational), ifu2idu_en and any of:
  - idu_rs1_used & rs1 != 0 & match(rs1), or the same for rs2.
  - match(x): FWD_EN=1 → entry0.valid & entry0.load & entry0.rd == x. FWD_EN=0 → any valid entry with rd == x.
- FSM states:
  - IDLE: enable=0 in any state → IDLE. Stalls = 1, bubble/flush = 0, scoreboard, counters and flush_cnt held. enable=1 → RUN, or FLUSH if flush_cnt != 0.
  - RUN: exu_redirect → FLUSH with flush_cnt = FLUSH_CYC-1. Flush outputs are high combinationally in the redirect cycle itself.
  - FLUSH: ctrl2ifu_flush = ctrl2idu_flush = ctrl2exu_bubble = 1 and stalls = 0. flush_cnt decrements each cycle; →RUN when it reaches 0. If FLUSH_CYC=1, the FSM returns to RUN directly. A new exu_redirect during FLUSH reloads flush_cnt = FLUSH_CYC-1.
- Outputs in RUN:
  - stalls = hazard.
  - ctrl2exu_bubble = hazard | !ifu2idu_en.
- Priority: redirect > hazard. A redirect during a hazard stall kills the stall in that same cycle.
- Latency:
  - Hazard to stall: 0 cycles (combinational).
  - Redirect to flush: 0 cycles.
  - A load issued at cycle t with dependent in ID at t+1 (FWD_EN=1) → stall exactly 1 cycle; issue at t+2.
- Counters:
  - perf_stall_cnt +1 per enabled cycle with hazard & no flush.
  - perf_flush_cnt +1 per enabled cycle with flush outputs high.
  - Both saturate at all-ones; no wrap.
- x0: never tracked, never causes a hazard.

Test Plan:
- Load-use, FWD_EN=1: lw x5 issued, next add x6,x5,x1 → stall=1 and bubble=1 for 1 cycle, add issues next cycle, perf_stall_cnt=1.
- No-forward, FWD_EN=0, NSTAGE=3: addi x7 followed by sub using x7 → 3 stall cycles, then issue; rd=x0 writer followed by reader of x0 → 0 stalls.
- Redirect, FLUSH_CYC=2: exu_redirect pulse → ifu/idu flush and bubble high for exactly 2 cycles, perf_flush_cnt=2; redirect coincident with load-use hazard → stall=0, flush=1.
- Back-to-back redirects: second pulse in the 2nd flush cycle → flush extends to 3 total cycles.
- Enable freeze: drop enable mid-FLUSH (1 cycle left) for 4 cycles → stalls=1, flush=0, counters hold; enable=1 → 1 remaining flush cycle, then RUN.
- Reset/saturation: rst_n low mid-stall → next cycle all scoreboard entries invalid, counters 0. With CNT_W=4 and 20 stall cycles → perf_stall_cnt=15.
